mem_readback_checker: RTL and testbench

MEM_READBACK_CHECKER -- requirements
Module: mem_readback_checker

---
 rtl/mem_readback_checker.sv | 151 +++++++++++++++
 tb/tb_mem_readback_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_readback_checker
// Description : Walks a dual-port memory two words per pass and compares each
//               word with an incrementing pattern (seed + offset). It only
//               reads; both write enables are tied low. It reports pass/fail,
//               a saturating mismatch count, the first mismatching address and
//               a 2x4-bit LED status display.
// Ports       : slow_clk, reset (sync, active-low)
//               start, base_addr, length, seed   - run request, sampled on
//                                                   an accepted start
//               addr1/addr2, wen1/wen2           - memory side (read only)
//               dout1/dout2                      - read data, 1-cycle latency
//               busy, done, pass, err_count,
//               first_err_addr                   - run status/results
//               LED1, LED2                       - board display
// Options     : `define MEM_CHECK_STOP_ON_ERR_EN ends a run at the first CHECK
//               that sees any mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_readback_checker #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              slow_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              wen1,
    output logic              wen2,
    input  logic [DATA_W-1:0] dout1,
    input  logic [DATA_W-1:0] dout2,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [3:0]        LED1,
    output logic [3:0]        LED2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_len;
    // One extra bit so offset + 2 past the largest length does not wrap.
    logic [ADDR_W:0]   r_offset;
    // Expected value for the port-1 word of the current pair.
    logic [DATA_W-1:0] r_exp;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [7:0]        r_err;
    logic [ADDR_W-1:0] r_first_err;

    logic              w_accept;
    logic              w_cmp2;
    logic              w_mis1;
    logic              w_mis2;
    logic [8:0]        w_err_sum;
    logic [ADDR_W:0]   w_next_off;
    logic              w_run_end;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Odd-length tail: the port-2 word lies beyond the run and is skipped.
    assign w_cmp2     = (r_offset + (ADDR_W+1)'(1)) < {1'b0, r_len};
    assign w_mis1     = (dout1 != r_exp);
    assign w_mis2     = w_cmp2 && (dout2 != (r_exp + DATA_W'(1)));
    assign w_err_sum  = {1'b0, r_err} + 9'(w_mis1) + 9'(w_mis2);
    assign w_next_off = r_offset + (ADDR_W+1)'(2);

`ifdef MEM_CHECK_STOP_ON_ERR_EN
    assign w_run_end  = (w_next_off >= {1'b0, r_len}) || w_mis1 || w_mis2;
`else
    assign w_run_end  = (w_next_off >= {1'b0, r_len});
`endif

    always_ff @(posedge slow_clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_offset    <= '0;
            r_exp       <= '0;
            r_addr1     <= '0;
            r_addr2     <= ADDR_W'(1);
            r_err       <= '0;
            r_first_err <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_len       <= length;
                        r_offset    <= '0;
                        r_exp       <= seed;
                        r_err       <= '0;
                        r_first_err <= '0;
                        if (length == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            // Address pair for the first READ; the +1 wraps
                            // modulo 2^ADDR_W.
                            r_addr1 <= base_addr;
                            r_addr2 <= base_addr + ADDR_W'(1);
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_err <= (w_err_sum > 9'd255) ? 8'd255 : w_err_sum[7:0];
                    // A zero count means no mismatch has been recorded yet.
                    if ((r_err == 8'd0) && (w_mis1 || w_mis2)) begin
                        r_first_err <= w_mis1 ? r_addr1 : r_addr2;
                    end
                    r_offset <= w_next_off;
                    r_exp    <= r_exp + DATA_W'(2);
                    if (w_run_end) begin
                        r_state <= S_DONE;
                    end else begin
                        r_addr1 <= r_addr1 + ADDR_W'(2);
                        r_addr2 <= r_addr2 + ADDR_W'(2);
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr1          = r_addr1;
    assign addr2          = r_addr2;
    assign wen1           = 1'b0;
    assign wen2           = 1'b0;
    assign busy           = (r_state == S_READ) || (r_state == S_CHECK);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err == 8'd0);
    assign err_count      = r_err;
    assign first_err_addr = r_first_err;
    assign LED1           = {done, pass, busy, (r_err != 8'd0)};
    assign LED2           = (r_err > 8'd15) ? 4'hF : r_err[3:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_readback_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_readback_checker
// Description : Directed self-checking bench for mem_readback_checker with a
//               1-cycle-latency dual-port memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_readback_checker;

    logic        slow_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  length;
    logic [15:0] seed;
    logic [9:0]  addr1, addr2;
    logic        wen1, wen2;
    logic [15:0] dout1, dout2;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [9:0]  first_err_addr;
    logic [3:0]  LED1, LED2;

    logic [15:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    mem_readback_checker #(.ADDR_W(10), .DATA_W(16)) dut (
        .slow_clk       (slow_clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .addr1          (addr1),
        .addr2          (addr2),
        .wen1           (wen1),
        .wen2           (wen2),
        .dout1          (dout1),
        .dout2          (dout2),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .LED1           (LED1),
        .LED2           (LED2)
    );

    always #5 slow_clk = ~slow_clk;

    always @(posedge slow_clk) begin
        dout1 <= mem[addr1];
        dout2 <= mem[addr2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic issue_start(input logic [9:0] b, input logic [9:0] l, input logic [15:0] s);
        @(negedge slow_clk);
        base_addr = b;
        length    = l;
        seed      = s;
        start     = 1'b1;
        @(negedge slow_clk);
        start     = 1'b0;
    endtask

    // Counts busy cycles until done; a missing done counts as a failure.
    task automatic wait_done(output int busy_cyc);
        int guard;
        busy_cyc = 0;
        guard    = 0;
        while (!done && guard < 2000) begin
            if (busy) busy_cyc++;
            guard++;
            @(negedge slow_clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL wait_done observed=timeout expected=done");
        end
    endtask

    task automatic run(input logic [9:0] b, input logic [9:0] l, input logic [15:0] s, output int busy_cyc);
        issue_start(b, l, s);
        wait_done(busy_cyc);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        reset = 1'b0; start = 1'b1; base_addr = '0; length = 10'd5; seed = '0;
        repeat (3) @(negedge slow_clk);
        chk("rst_addr1", addr1, 0);
        chk("rst_addr2", addr2, 1);
        chk("rst_wen", {wen1, wen2}, 0);
        chk("rst_status", {busy, done, pass}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_addr, 0);
        chk("rst_leds", {LED1, LED2}, 0);
        start = 1'b0; reset = 1'b1;
        @(negedge slow_clk);
        chk("rst_start_ignored", {busy, done}, 0);

        // Matching pair
        mem[0] = 16'h0004; mem[1] = 16'h0005;
        run(10'd0, 10'd2, 16'h0004, cyc);
        chk("t1_busy_cycles", cyc, 2);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_count, 0);
        chk("t1_led1", LED1, 4'b1100);
        chk("t1_led2", LED2, 4'h0);

        // Port-2 mismatch
        mem[1] = 16'h0002;
        run(10'd0, 10'd2, 16'h0004, cyc);
        chk("t2_pass", pass, 0);
        chk("t2_err", err_count, 1);
        chk("t2_first", first_err_addr, 1);
        chk("t2_led1", LED1, 4'b1001);
        chk("t2_led2", LED2, 4'h1);

        // Address wrap at top of memory
        mem[1022] = 16'hFFFF; mem[1023] = 16'h0000; mem[0] = 16'h0001; mem[1] = 16'h0002;
        issue_start(10'd1022, 10'd4, 16'hFFFF);
        chk("t3_read1_addr1", addr1, 1022);
        chk("t3_read1_addr2", addr2, 1023);
        @(negedge slow_clk);
        @(negedge slow_clk);
        chk("t3_read2_addr1", addr1, 0);
        chk("t3_read2_addr2", addr2, 1);
        wait_done(cyc);
        chk("t3_pass", pass, 1);
        chk("t3_err", err_count, 0);

        // Odd length: word at base+3 is outside the run
        mem[100] = 16'h0010; mem[101] = 16'h0011; mem[102] = 16'h0012; mem[103] = 16'h0BAD;
        run(10'd100, 10'd3, 16'h0010, cyc);
        chk("t4_busy_cycles", cyc, 4);
        chk("t4_pass", pass, 1);
        chk("t4_hold_addr1", addr1, 102);
        chk("t4_hold_addr2", addr2, 103);

        // Zero length
        run(10'd0, 10'd0, 16'h0000, cyc);
        chk("t5_busy_cycles", cyc, 0);
        chk("t5_pass", {done, pass}, 2'b11);
        chk("t5_addr_held", addr1, 102);

        // Odd-length tail mismatch on port 1
        mem[102] = 16'h0000;
        run(10'd100, 10'd3, 16'h0010, cyc);
        chk("t6_err", err_count, 1);
        chk("t6_first", first_err_addr, 102);
        mem[102] = 16'h0012;

        // Start during busy ignored
        issue_start(10'd100, 10'd3, 16'h0010);
        base_addr = 10'd500; length = 10'd0; start = 1'b1;
        @(negedge slow_clk);
        start = 1'b0;
        chk("t7_ignored_addr1", addr1, 100);
        wait_done(cyc);
        chk("t7_busy_cycles", cyc, 3);
        chk("t7_pass", pass, 1);

        // Reset mid-run, while in CHECK
        issue_start(10'd100, 10'd3, 16'h0010);
        @(negedge slow_clk);
        chk("t8_in_check", busy, 1);
        reset = 1'b0;
        @(negedge slow_clk);
        chk("t8_addrs", {addr1, addr2}, {10'd0, 10'd1});
        chk("t8_status", {busy, done, pass, wen1, wen2}, 0);
        chk("t8_results", {err_count, first_err_addr, LED1, LED2}, 0);
        reset = 1'b1;

        // All words mismatching
        for (int i = 200; i < 500; i++) mem[i] = 16'h0000;
        run(10'd200, 10'd20, 16'h1000, cyc);
        chk("t9_first", first_err_addr, 200);
        chk("t9_pass", pass, 0);
`ifdef MEM_CHECK_STOP_ON_ERR_EN
        chk("t9_err", err_count, 2);
        chk("t9_busy_cycles", cyc, 2);
        chk("t9_led2", LED2, 4'h2);
`else
        chk("t9_err", err_count, 20);
        chk("t9_busy_cycles", cyc, 20);
        chk("t9_led2", LED2, 4'hF);
`endif

        // Saturation of the mismatch count
        run(10'd200, 10'd300, 16'h1000, cyc);
`ifdef MEM_CHECK_STOP_ON_ERR_EN
        chk("t10_err", err_count, 2);
`else
        chk("t10_err", err_count, 255);
        chk("t10_busy_cycles", cyc, 300);
`endif
        chk("t10_led", {LED1, LED2}, {4'b1001, 4'hF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
